// File: rtl/progtim.sv
// rtl/progtim.sv - prescaled compare/match timer on the 8-bit chip-select bus
// Optional external capture input enabled by PROGTIM_EXTCAP_EN.
module progtim #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq
`ifdef PROGTIM_EXTCAP_EN
  ,
  input  logic       cap_in
`endif
);

  localparam int NB = CNT_W / 8;

  logic             rd, wr;
  logic             wr_ctrl, wr_status, wr_pre, wr_capture;
  logic [CNT_W-1:0] cnt, cmp, capt;
  logic [PRE_W-1:0] prescale, pre;
  logic             en, periodic, irq_en, match, ext_cap;
  logic             tick, hit, ext_edge;
  logic [15:0]      pre_wdata, pre_rdata;
  logic [31:0]      capt_w, cmp_w;

  assign rd         = !cs_n && !rd_n && wr_n;
  assign wr         = !cs_n && rd_n && !wr_n;
  assign wr_ctrl    = wr && (addr == 4'd4);
  assign wr_status  = wr && (addr == 4'd5);
  assign wr_pre     = wr && (addr == 4'd6);
  assign wr_capture = wr && (addr == 4'd7);

  assign tick = en && (pre == '0);
  // compare always sees the pre-write CMP, so a byte write on a tick edge takes effect next cycle
  assign hit  = (cnt == cmp);
  assign irq  = match && irq_en;

  assign pre_wdata = 16'(data_in);
  assign pre_rdata = 16'(prescale);
  assign capt_w    = 32'(capt);
  assign cmp_w     = 32'(cmp);

`ifdef PROGTIM_EXTCAP_EN
  logic [2:0] cap_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap_sync <= '0;
    else       cap_sync <= {cap_sync[1:0], cap_in};
  end

  assign ext_edge = cap_sync[1] && !cap_sync[2];
`else
  assign ext_edge = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      capt     <= '0;
      cmp      <= '1;
      prescale <= '0;
      pre      <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      match    <= 1'b0;
      ext_cap  <= 1'b0;
    end else begin
      if (wr_pre) prescale <= pre_wdata[PRE_W-1:0];

      for (int b = 0; b < NB; b++) begin
        if (wr && (addr == 4'(8 + b))) cmp[b*8 +: 8] <= data_in;
      end

      if (wr_capture || ext_edge) capt <= cnt;

      if (ext_edge)                     ext_cap <= 1'b1;
      else if (wr_status && data_in[2]) ext_cap <= 1'b0;

      if (tick && hit)                  match <= 1'b1;
      else if (wr_status && data_in[0]) match <= 1'b0;

      // a CTRL write overrides the one-shot auto-disable on the same edge
      if (wr_ctrl) begin
        en       <= data_in[0];
        periodic <= data_in[1];
        irq_en   <= data_in[2];
      end else if (tick && hit && !periodic) begin
        en <= 1'b0;
      end

      if (wr_ctrl && data_in[0] && !en) pre <= prescale;
      else if (tick)                    pre <= prescale;
      else if (en)                      pre <= pre - PRE_W'(1);

      if (tick) cnt <= hit ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (rd) begin
      case (addr)
        4'd0, 4'd1, 4'd2, 4'd3:   data_out = capt_w[{addr[1:0], 3'b000} +: 8];
        4'd4:                     data_out = {5'b0, irq_en, periodic, en};
        4'd5:                     data_out = {5'b0, ext_cap, en, match};
        4'd6:                     data_out = pre_rdata[7:0];
        4'd8, 4'd9, 4'd10, 4'd11: data_out = cmp_w[{addr[1:0], 3'b000} +: 8];
        default:                  data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_progtim.sv
// tb/tb_progtim.sv - directed self-checking bench for progtim (32-bit and 8-bit builds)
module tb_progtim;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1, cs_n8 = 1'b1;
  logic       rd_n = 1'b1, wr_n = 1'b1;
  logic [3:0] addr = 4'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out, data_out8;
  logic       irq, irq8;
  logic       cap_in = 1'b0;
  logic [7:0] rv;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  progtim #(.CNT_W(32), .PRE_W(8)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data_in(data_in), .data_out(data_out), .irq(irq)
`ifdef PROGTIM_EXTCAP_EN
    , .cap_in(cap_in)
`endif
  );

  progtim #(.CNT_W(8), .PRE_W(8)) dut8 (
    .clk(clk), .reset(reset), .cs_n(cs_n8), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data_in(data_in), .data_out(data_out8), .irq(irq8)
`ifdef PROGTIM_EXTCAP_EN
    , .cap_in(cap_in)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one write edge; returns 1 time unit after that edge
  task automatic bus_wr(input logic sel8, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data_in = d;
    if (sel8) cs_n8 = 1'b0;
    else      cs_n = 1'b0;
    wr_n = 1'b0;
    @(posedge clk);
    #1;
    cs_n = 1'b1;
    cs_n8 = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic sel8, input logic [3:0] a, input logic [7:0] exp);
    addr = a;
    if (sel8) cs_n8 = 1'b0;
    else      cs_n = 1'b0;
    rd_n = 1'b0;
    #1;
    rv = sel8 ? data_out8 : data_out;
    cs_n = 1'b1;
    cs_n8 = 1'b1;
    rd_n = 1'b1;
    #1;
    check(tag, 32'(rv), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    // reset state
    check("idle_data_out", 32'(data_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rd_chk("reset_cmp0", 1'b0, 4'd8, 8'hFF);
    rd_chk("reset_cmp3", 1'b0, 4'd11, 8'hFF);
    rd_chk("reset_ctrl", 1'b0, 4'd4, 8'h00);
    rd_chk("reset_status", 1'b0, 4'd5, 8'h00);
    rd_chk("reserved_12", 1'b0, 4'd12, 8'h00);

    // periodic: PRESCALE=0, CMP=9, match every 10 clk
    bus_wr(1'b0, 4'd8, 8'd9);
    bus_wr(1'b0, 4'd9, 8'd0);
    bus_wr(1'b0, 4'd10, 8'd0);
    bus_wr(1'b0, 4'd11, 8'd0);
    rd_chk("cmp0_readback", 1'b0, 4'd8, 8'h09);
    bus_wr(1'b0, 4'd4, 8'h07);
    repeat (9) @(posedge clk);
    #1 check("per_irq_before", 32'(irq), 32'h0);
    @(posedge clk);
    #1 check("per_irq_match1", 32'(irq), 32'h1);
    rd_chk("per_status", 1'b0, 4'd5, 8'h03);
    bus_wr(1'b0, 4'd5, 8'h01);
    check("per_irq_w1c", 32'(irq), 32'h0);
    repeat (8) @(posedge clk);
    #1 check("per_irq_before2", 32'(irq), 32'h0);
    @(posedge clk);
    #1 check("per_irq_match2", 32'(irq), 32'h1);
    // async reset mid-count
    reset = 1'b1;
    #1;
    check("async_rst_irq", 32'(irq), 32'h0);
    rd_chk("async_rst_ctrl", 1'b0, 4'd4, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // one-shot: PRESCALE=3, CMP=4 -> match 20 clk after enable
    bus_wr(1'b0, 4'd6, 8'd3);
    bus_wr(1'b0, 4'd8, 8'd4);
    bus_wr(1'b0, 4'd9, 8'd0);
    bus_wr(1'b0, 4'd10, 8'd0);
    bus_wr(1'b0, 4'd11, 8'd0);
    rd_chk("pre_readback", 1'b0, 4'd6, 8'h03);
    bus_wr(1'b0, 4'd4, 8'h05);
    repeat (19) @(posedge clk);
    #1 rd_chk("os_status_before", 1'b0, 4'd5, 8'h02);
    @(posedge clk);
    #1 rd_chk("os_status_match", 1'b0, 4'd5, 8'h01);
    rd_chk("os_ctrl_cleared", 1'b0, 4'd4, 8'h04);
    check("os_irq", 32'(irq), 32'h1);
    repeat (10) @(posedge clk);
    bus_wr(1'b0, 4'd7, 8'h00);
    rd_chk("os_cnt_held", 1'b0, 4'd0, 8'h00);
    do_reset();

    // capture after 300 ticks of a free-running counter
    bus_wr(1'b0, 4'd4, 8'h01);
    repeat (300) @(posedge clk);
    bus_wr(1'b0, 4'd7, 8'h00);
    rd_chk("capt_b0", 1'b0, 4'd0, 8'h2C);
    rd_chk("capt_b1", 1'b0, 4'd1, 8'h01);
    rd_chk("capt_b2", 1'b0, 4'd2, 8'h00);
    rd_chk("capture_reg_reads0", 1'b0, 4'd7, 8'h00);
    do_reset();

`ifdef PROGTIM_EXTCAP_EN
    // cap_in rises with cnt=48; 3 clk of sync/edge latency lands the capture at cnt=50
    bus_wr(1'b0, 4'd4, 8'h01);
    repeat (48) @(posedge clk);
    @(negedge clk);
    cap_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cap_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rd_chk("extcap_capt", 1'b0, 4'd0, 8'd50);
    rd_chk("extcap_status", 1'b0, 4'd5, 8'h06);
    bus_wr(1'b0, 4'd5, 8'h04);
    rd_chk("extcap_w1c", 1'b0, 4'd5, 8'h02);
`else
    bus_wr(1'b0, 4'd4, 8'h01);
    repeat (20) @(posedge clk);
    #1 rd_chk("no_extcap_status", 1'b0, 4'd5, 8'h02);
`endif
    do_reset();

    // 8-bit build: upper bytes absent, wrap through match at CMP=FF
    bus_wr(1'b1, 4'd1, 8'h5A);
    rd_chk("w8_capt1_ignored", 1'b1, 4'd1, 8'h00);
    rd_chk("w8_cmp1_absent", 1'b1, 4'd9, 8'h00);
    rd_chk("w8_cmp0", 1'b1, 4'd8, 8'hFF);
    bus_wr(1'b1, 4'd4, 8'h03);
    repeat (255) @(posedge clk);
    #1 rd_chk("w8_before_wrap", 1'b1, 4'd5, 8'h02);
    bus_wr(1'b1, 4'd5, 8'h01);
    rd_chk("w8_set_beats_w1c", 1'b1, 4'd5, 8'h03);
    bus_wr(1'b1, 4'd7, 8'h00);
    rd_chk("w8_wrapped_cnt", 1'b1, 4'd0, 8'h00);
    bus_wr(1'b1, 4'd5, 8'h01);
    rd_chk("w8_w1c_clears", 1'b1, 4'd5, 8'h02);
    check("w8_irq_masked", 32'(irq8), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
